// File: rtl/end_generate_if.sv
// TX bus between the MAC datapath and the 64b/66b encoder.
// The master drives one XGMII-style word per cycle; the slave returns 66-bit blocks.
interface end_generate_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned KEEP_W = DATA_W / 8
);
    logic              idle_v_i;
    logic [DATA_W-1:0] data_i;
    logic [KEEP_W-1:0] keep_i;
    logic              start_i;
    logic              last_i;
    logic              err_i;
    logic              ready_o;
    logic              head_v_o;
    logic [1:0]        sync_head_o;
    logic [DATA_W-1:0] data_o;

    modport master (
        output idle_v_i, data_i, keep_i, start_i, last_i, err_i,
        input  ready_o, head_v_o, sync_head_o, data_o
    );

    modport slave (
        input  idle_v_i, data_i, keep_i, start_i, last_i, err_i,
        output ready_o, head_v_o, sync_head_o, data_o
    );
endinterface

// File: rtl/end_generate.sv
// Lite 10GBASE-R PCS 64b/66b transmit encoder: one word in, one 66-bit block out per cycle.
// Optional build macro PCS_SCRAMBLE_EN adds the x^58+x^39+1 self-synchronizing scrambler on data_o.
module end_generate #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned KEEP_W       = DATA_W / 8,
    parameter int unsigned BLOCK_TYPE_W = 8
) (
    input  logic         clk,
    input  logic         nreset,
    end_generate_if.slave bus
);
    localparam int unsigned PL_W = DATA_W - BLOCK_TYPE_W;

    localparam logic [1:0]        SYNC_DATA = 2'b01;
    localparam logic [1:0]        SYNC_CTRL = 2'b10;
    localparam logic [DATA_W-1:0] BLK_IDLE  = DATA_W'(64'h1E);
    localparam logic [DATA_W-1:0] BLK_ERR   = {{8{7'h1E}}, 8'h1E};
    localparam logic [DATA_W-1:0] BLK_TERM0 = DATA_W'(64'h87);
    localparam logic [BLOCK_TYPE_W-1:0] TYPE_START = BLOCK_TYPE_W'(8'h78);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DATA      = 2'd1,
        S_TERM_PEND = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                head_v_q;
    logic [1:0]          sync_q, sync_d;
    logic [DATA_W-1:0]   data_q, blk_d, data_nx;

    logic [PL_W-1:0]         term_mask;
    logic [BLOCK_TYPE_W-1:0] term_type;
    logic [3:0]              n_bytes;
    logic                    keep_contig;
    logic                    keep_full;
    logic [DATA_W-1:0]       blk_term;
    logic [DATA_W-1:0]       blk_start;

    // Terminate block: keep the first n bytes behind the type field, zero the rest.
    always_comb begin
        term_mask = '0;
        for (int i = 0; i < KEEP_W - 1; i++) begin
            term_mask[8*i +: 8] = {8{bus.keep_i[i]}};
        end
        n_bytes     = 4'($countones(bus.keep_i));
        keep_full   = (bus.keep_i == 8'hFF);
        keep_contig = ((bus.keep_i & (bus.keep_i + 8'd1)) == 8'd0);
        case (n_bytes)
            4'd0:    term_type = 8'h87;
            4'd1:    term_type = 8'h99;
            4'd2:    term_type = 8'hAA;
            4'd3:    term_type = 8'hB4;
            4'd4:    term_type = 8'hCC;
            4'd5:    term_type = 8'hD2;
            4'd6:    term_type = 8'hE1;
            default: term_type = 8'hFF;
        endcase
        blk_term  = {bus.data_i[PL_W-1:0] & term_mask, term_type};
        blk_start = {bus.data_i[DATA_W-1:BLOCK_TYPE_W], TYPE_START};
    end

    // Next-state and next-block selection.
    always_comb begin
        state_d = state_q;
        sync_d  = SYNC_CTRL;
        blk_d   = BLK_ERR;
        case (state_q)
            S_IDLE: begin
                if (bus.err_i) begin
                    blk_d = BLK_ERR;
                end else if (bus.idle_v_i) begin
                    blk_d = BLK_IDLE;
                end else if (bus.start_i) begin
                    blk_d   = blk_start;
                    state_d = bus.last_i ? S_TERM_PEND : S_DATA;
                end else begin
                    blk_d = BLK_ERR;
                end
            end
            S_DATA: begin
                if (bus.err_i) begin
                    blk_d = BLK_ERR;
                    if (bus.last_i) state_d = S_IDLE;
                end else if (bus.idle_v_i) begin
                    blk_d   = BLK_ERR;
                    state_d = S_IDLE;
                end else if (bus.last_i && keep_full) begin
                    sync_d  = SYNC_DATA;
                    blk_d   = bus.data_i;
                    state_d = S_TERM_PEND;
                end else if (bus.last_i && keep_contig) begin
                    blk_d   = blk_term;
                    state_d = S_IDLE;
                end else if (bus.last_i) begin
                    blk_d   = BLK_ERR;
                    state_d = S_IDLE;
                end else begin
                    sync_d = SYNC_DATA;
                    blk_d  = bus.data_i;
                end
            end
            S_TERM_PEND: begin
                blk_d   = BLK_TERM0;
                state_d = S_IDLE;
            end
            default: begin
                blk_d   = BLK_ERR;
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef PCS_SCRAMBLE_EN
    logic [57:0]       scr_q, scr_d;
    logic [DATA_W-1:0] scr_out;

    // Serial x^58+x^39+1 scrambler unrolled over the 64 payload bits, LSB first.
    always_comb begin
        scr_d   = scr_q;
        scr_out = '0;
        for (int i = 0; i < DATA_W; i++) begin
            scr_out[i] = blk_d[i] ^ scr_d[38] ^ scr_d[57];
            scr_d      = {scr_d[56:0], scr_out[i]};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) scr_q <= '1;
        else         scr_q <= scr_d;
    end

    assign data_nx = scr_out;
`else
    assign data_nx = blk_d;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            head_v_q <= 1'b0;
            sync_q   <= SYNC_CTRL;
            data_q   <= BLK_IDLE;
        end else begin
            state_q  <= state_d;
            head_v_q <= 1'b1;
            sync_q   <= sync_d;
            data_q   <= data_nx;
        end
    end

    assign bus.ready_o     = (state_q != S_TERM_PEND);
    assign bus.head_v_o    = head_v_q;
    assign bus.sync_head_o = sync_q;
    assign bus.data_o      = data_q;
endmodule

// File: tb/tb_end_generate.sv
// Directed vector bench for end_generate: one table of per-cycle stimulus and expected block,
// plus an asynchronous mid-packet reset sequence.
module tb_end_generate;
    localparam logic [63:0] ERR  = {{8{7'h1E}}, 8'h1E};
    localparam logic [63:0] IDL  = 64'h1E;
    localparam logic [63:0] PRE  = 64'hD5555555555555FB;
    localparam logic [63:0] PREO = 64'hD555555555555578;

    logic clk;
    logic nreset;
    int   n_cmp;
    int   n_bad;

    end_generate_if bus ();

    end_generate dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        idle_v;
        logic        start;
        logic        last;
        logic        err;
        logic [7:0]  keep;
        logic [63:0] data;
        logic        exp_ready;
        logic [1:0]  exp_sync;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic st, input logic la, input logic er,
                                input logic [7:0] kp, input logic [63:0] d,
                                input logic rdy, input logic [1:0] sy, input logic [63:0] ed);
        vec_t v;
        v.idle_v = iv; v.start = st; v.last = la; v.err = er;
        v.keep = kp; v.data = d;
        v.exp_ready = rdy; v.exp_sync = sy; v.exp_data = ed;
        return v;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.idle_v_i = v.idle_v;
        bus.start_i  = v.start;
        bus.last_i   = v.last;
        bus.err_i    = v.err;
        bus.keep_i   = v.keep;
        bus.data_i   = v.data;
    endtask

    // Drive on the falling edge, check ready before the rising edge and the block just after.
    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check1($sformatf("v%0d ready", idx), bus.ready_o, v.exp_ready);
        @(posedge clk);
        #1;
        check1($sformatf("v%0d head_v", idx), bus.head_v_o, 1'b1);
        check2($sformatf("v%0d sync", idx), bus.sync_head_o, v.exp_sync);
        check64($sformatf("v%0d data", idx), bus.data_o, v.exp_data);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nreset = 1'b0;
        drive(mk(1, 0, 0, 0, 8'hFF, 64'h0, 1, 2'b10, IDL));

        //           idle st la er keep   data                   rdy sync   expected
        vecs.push_back(mk(1, 0, 0, 0, 8'hFF, 64'h0,                 1, 2'b10, IDL));
        vecs.push_back(mk(1, 0, 0, 0, 8'hFF, 64'h0,                 1, 2'b10, IDL));
        vecs.push_back(mk(1, 0, 0, 0, 8'hFF, 64'h0,                 1, 2'b10, IDL));
        vecs.push_back(mk(0, 1, 0, 0, 8'hFF, PRE,                   1, 2'b10, PREO));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 64'h0123456789ABCDEF,  1, 2'b01, 64'h0123456789ABCDEF));
        vecs.push_back(mk(0, 0, 1, 0, 8'h07, 64'hFFFFFFFFFFAABBCC,  1, 2'b10, 64'h00000000AABBCCB4));
        vecs.push_back(mk(0, 1, 0, 0, 8'hFF, PRE,                   1, 2'b10, PREO));
        vecs.push_back(mk(0, 0, 1, 0, 8'hFF, 64'h1122334455667788,  1, 2'b01, 64'h1122334455667788));
        vecs.push_back(mk(0, 1, 0, 1, 8'h01, 64'hDEADBEEFDEADBEEF,  0, 2'b10, 64'h87));
        vecs.push_back(mk(1, 0, 0, 0, 8'hFF, 64'h0,                 1, 2'b10, IDL));
        vecs.push_back(mk(0, 1, 0, 0, 8'hFF, PRE,                   1, 2'b10, PREO));
        vecs.push_back(mk(0, 0, 0, 1, 8'hFF, 64'h5A5A5A5A5A5A5A5A,  1, 2'b10, ERR));
        vecs.push_back(mk(0, 1, 0, 0, 8'hFF, 64'hCAFEF00DCAFEF00D,  1, 2'b01, 64'hCAFEF00DCAFEF00D));
        vecs.push_back(mk(0, 0, 1, 1, 8'hFF, 64'h0,                 1, 2'b10, ERR));
        vecs.push_back(mk(0, 0, 0, 0, 8'hFF, 64'h0123456789ABCDEF,  1, 2'b10, ERR));
        vecs.push_back(mk(0, 1, 0, 0, 8'hFF, PRE,                   1, 2'b10, PREO));
        vecs.push_back(mk(1, 0, 0, 0, 8'hFF, 64'h0,                 1, 2'b10, ERR));
        vecs.push_back(mk(0, 0, 0, 0, 8'hFF, 64'h0123456789ABCDEF,  1, 2'b10, ERR));
        vecs.push_back(mk(0, 1, 0, 0, 8'hFF, PRE,                   1, 2'b10, PREO));
        vecs.push_back(mk(0, 0, 1, 0, 8'h05, 64'h0000000000112233,  1, 2'b10, ERR));
        vecs.push_back(mk(0, 1, 1, 0, 8'hFF, 64'hA1B2C3D4E5F60718,  1, 2'b10, 64'hA1B2C3D4E5F60778));
        vecs.push_back(mk(1, 0, 0, 0, 8'hFF, 64'h0,                 0, 2'b10, 64'h87));
        vecs.push_back(mk(0, 1, 0, 0, 8'hFF, PRE,                   1, 2'b10, PREO));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 64'hFFFFFFFFFFFFFFFF,  1, 2'b10, 64'h87));
        vecs.push_back(mk(0, 1, 0, 0, 8'hFF, PRE,                   1, 2'b10, PREO));
        vecs.push_back(mk(0, 0, 1, 0, 8'h7F, 64'hAA11223344556677,  1, 2'b10, 64'h11223344556677FF));
        vecs.push_back(mk(0, 1, 0, 0, 8'hFF, PRE,                   1, 2'b10, PREO));
        vecs.push_back(mk(0, 0, 1, 0, 8'h01, 64'h00000000000000AB,  1, 2'b10, 64'h000000000000AB99));

        // Reset state.
        #12;
        check1("rst head_v", bus.head_v_o, 1'b0);
        check2("rst sync", bus.sync_head_o, 2'b10);
        check64("rst data", bus.data_o, IDL);
        check1("rst ready", bus.ready_o, 1'b1);
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Mid-packet asynchronous reset, away from any clock edge.
        apply(100, mk(0, 1, 0, 0, 8'hFF, PRE, 1, 2'b10, PREO));
        apply(101, mk(0, 0, 1, 0, 8'hFF, 64'h0F0F0F0F0F0F0F0F, 1, 2'b01, 64'h0F0F0F0F0F0F0F0F));
        #2;
        nreset = 1'b0;
        #1;
        check1("arst head_v", bus.head_v_o, 1'b0);
        check2("arst sync", bus.sync_head_o, 2'b10);
        check64("arst data", bus.data_o, IDL);
        check1("arst ready", bus.ready_o, 1'b1);
        @(negedge clk);
        nreset = 1'b1;
        apply(102, mk(0, 0, 0, 0, 8'hFF, 64'h0123456789ABCDEF, 1, 2'b10, ERR));
        apply(103, mk(1, 0, 0, 0, 8'hFF, 64'h0, 1, 2'b10, IDL));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/end_generate.md
Name: end_generate

Overview:
- Lite 10GBASE-R PCS 64b/66b transmit encoder.
- Takes one 64-bit XGMII-style word per cycle with byte keep and start/last/idle/error flags.
- Emits one 66-bit block per cycle as a 2-bit sync header plus a 64-bit payload.
- Sits between the MAC TX datapath and the PCS scrambler/gearbox.

Parameters:
DATA_W, 64, data width in bits; only 64 is supported.
KEEP_W, DATA_W/8, byte-keep width.
BLOCK_TYPE_W, 8, block type field width.

Ports:
clk  in  1  clock
nreset  in  1  asynchronous active-low reset
idle_v_i  in  1  no packet data this cycle; send idle
data_i  in  64  TX data; byte 0 is bits [7:0]
keep_i  in  8  byte valid mask; must be contiguous from bit 0
start_i  in  1  first word of packet; byte 0 is replaced by the block type
last_i  in  1  last word of packet
err_i  in  1  send an error block
ready_o  out  1  inputs accepted this cycle (combinational)
head_v_o  out  1  output block valid
sync_head_o  out  2  2'b01 = data block, 2'b10 = control block
data_o  out  64  block payload; block type in [7:0] for control blocks

Behaviour:
- Timing:
  - All outputs are registered: 1-cycle latency from accepted input to output.
  - One block per cycle.
- Reset (asynchronous, nreset=0):
  - FSM goes to IDLE.
  - head_v_o=0, sync_head_o=2'b10, data_o=64'h1E.
  - ready_o=1.
- head_v_o is 1 on every clock edge after reset release.
- ready_o = (state != TERM_PEND). When ready_o=0, all inputs are ignored.
- Control payload encoding, as {payload[55:0], type[7:0]}:
  - Idle block: type 0x1E, payload all zero.
  - Error block: type 0x1E, payload {8{7'h1E}}.
  - Start block: type 0x78, payload = data_i[63:8].
  - Terminate with n valid bytes (n = popcount(keep_i), 0..7):
    - Types for n=0..7: 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF.
    - payload[8n-1:0] = data_i[8n-1:0]; remaining payload bits are zero.
- Data block: sync 2'b01, data_o = data_i.
- FSM states: IDLE, DATA, TERM_PEND.
- IDLE:
  - err_i: error block; stay IDLE.
  - idle_v_i: idle block.
  - start_i and not last_i: start block; go to DATA.
  - start_i and last_i: start block; go to TERM_PEND.
  - Any other non-idle word (no start): error block; stay IDLE.
- DATA (priority order):
  - err_i: error block. Go to IDLE if last_i, else stay DATA.
  - idle_v_i: error block; go to IDLE (packet aborted).
  - last_i with keep_i=8'hFF: data block; go to TERM_PEND.
  - last_i with contiguous partial keep: terminate block with n bytes; go to IDLE.
  - last_i with non-contiguous keep: error block; go to IDLE.
  - Otherwise: data block. start_i is ignored in DATA.
- TERM_PEND: emit terminate block with n=0 (64'h87); go to IDLE.
- Sync header is 2'b10 for every control block and 2'b01 only for data blocks.
- keep_i is only evaluated when last_i=1; otherwise it is treated as 8'hFF.

Optional Feature:
- Macro: PCS_SCRAMBLE_EN.
- When defined:
  - data_o is passed through the self-synchronizing scrambler x^58+x^39+1, LSB first, before the output register.
  - sync_head_o is never scrambled.
  - Scrambler state resets asynchronously to all ones and advances only when head_v_o is produced.
- When undefined: data_o is the raw block as specified. All test values below assume it is undefined.

Test Plan:
- Reset release, then idle_v_i=1 for 3 cycles -> each following cycle head_v_o=1, sync_head_o=2'b10, data_o=64'h1E.
- IDLE, start_i=1, data_i=64'hD5555555555555FB -> data_o=64'hD555555555555578, sync 10. Next word data_i=64'h0123456789ABCDEF -> data_o=64'h0123456789ABCDEF, sync 01.
- DATA, last_i=1, keep_i=8'h07, data_i[23:0]=24'hAABBCC -> data_o=64'h00000000AABBCCB4, sync 10; FSM returns to IDLE.
- DATA, last_i=1, keep_i=8'hFF:
  - Cycle 1 -> data block, sync 01.
  - Next cycle -> ready_o=0; stimulus driven that cycle is ignored.
  - Cycle 2 output -> data_o=64'h87, sync 10.
  - Then ready_o=1.
- DATA, err_i=1 -> data_o={{8{7'h1E}}, 8'h1E}, sync 10; FSM stays DATA. IDLE with data word and no start_i -> same error block.
- nreset asserted mid-packet (not clock aligned) -> outputs immediately at reset values. After release, a data word with no start_i produces an error block (FSM was IDLE).
